// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: request bundle, grant states, RAM address width.
package ram_arb_pkg;

  localparam int RAM_AW = 21;

  typedef struct packed {
    logic              cen;
    logic              wen;
    logic [3:0]        ben;
    logic [RAM_AW-1:0] a;
    logic [31:0]       di;
  } ram_req_t;

  // Encoding doubles as the GNT debug output: 00 idle, 01 CPU, 10 DMA.
  typedef enum logic [1:0] {
    RA_IDLE = 2'b00,
    RA_CPU  = 2'b01,
    RA_DMA  = 2'b10
  } ram_arb_st_t;

endpackage

// File: rtl/ram_arb_if.sv
// Bus bundle between CPU port, DMA port and RAM pins; slave is the arbiter's view.
// Handshake: a requester holds its CEn low until it samples its READYn low;
// the RAM drives MEM_READYn low for exactly one CLK per access.
interface ram_arb_if
  import ram_arb_pkg::*;
#(
  parameter int AW = RAM_AW
);
  logic          CPU_CEn;
  logic          CPU_WEn;
  logic [3:0]    CPU_BEn;
  logic [AW-1:0] CPU_A;
  logic [31:0]   CPU_DI;
  logic          CPU_READYn;
  logic          DMA_CEn;
  logic          DMA_WEn;
  logic [3:0]    DMA_BEn;
  logic [AW-1:0] DMA_A;
  logic [31:0]   DMA_DI;
  logic          DMA_READYn;
  logic [31:0]   RD_DO;
  logic          MEM_CEn;
  logic          MEM_WEn;
  logic [3:0]    MEM_BEn;
  logic [AW-1:0] MEM_A;
  logic [31:0]   MEM_DI;
  logic [31:0]   MEM_DO;
  logic          MEM_READYn;
  logic [1:0]    GNT;

  modport slave (
    input  CPU_CEn, CPU_WEn, CPU_BEn, CPU_A, CPU_DI,
    input  DMA_CEn, DMA_WEn, DMA_BEn, DMA_A, DMA_DI,
    input  MEM_DO, MEM_READYn,
    output CPU_READYn, DMA_READYn, RD_DO,
    output MEM_CEn, MEM_WEn, MEM_BEn, MEM_A, MEM_DI, GNT
  );

  modport master (
    output CPU_CEn, CPU_WEn, CPU_BEn, CPU_A, CPU_DI,
    output DMA_CEn, DMA_WEn, DMA_BEn, DMA_A, DMA_DI,
    output MEM_DO, MEM_READYn,
    input  CPU_READYn, DMA_READYn, RD_DO,
    input  MEM_CEn, MEM_WEn, MEM_BEn, MEM_A, MEM_DI, GNT
  );

endinterface

// File: rtl/ram_arb.sv
// Shares the core RAM between the CPU bus path and a DMA master, one access per grant,
// with DMA bursts capped at DMA_BURST consecutive grants while the CPU is waiting.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int DMA_BURST = 4,
  parameter int AW        = RAM_AW
) (
  input  logic     CLK,
  input  logic     RESn,
  ram_arb_if.slave bus
);

  localparam logic [3:0] BURST_MAX = 4'(DMA_BURST);

  ram_arb_st_t st_q, st_d;
  logic [3:0]  bc_q, bc_d;
  logic        cpu_rdy_n, dma_rdy_n;
  ram_req_t    cpu_req, dma_req, mem_req;

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      st_q <= RA_IDLE;
      bc_q <= 4'd0;
    end else begin
      st_q <= st_d;
      bc_q <= bc_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    bc_d      = bc_q;
    cpu_rdy_n = 1'b1;
    dma_rdy_n = 1'b1;
    unique case (st_q)
      RA_IDLE: begin
        if (!bus.DMA_CEn && (bus.CPU_CEn || (bc_q < BURST_MAX))) begin
          st_d = RA_DMA;
        end else if (!bus.CPU_CEn) begin
          st_d = RA_CPU;
        end
      end
      RA_CPU: begin
        if (!bus.MEM_READYn) begin
          st_d      = RA_IDLE;
          bc_d      = 4'd0;
          // A withdrawn requester (CEn back high) gets no completion strobe.
          cpu_rdy_n = bus.CPU_CEn;
        end
      end
      RA_DMA: begin
        if (!bus.MEM_READYn) begin
          st_d      = RA_IDLE;
          dma_rdy_n = bus.DMA_CEn;
          if (!bus.CPU_CEn) begin
            bc_d = (bc_q == 4'hF) ? bc_q : bc_q + 4'd1;
          end else begin
            bc_d = 4'd0;
          end
        end
      end
      default: st_d = RA_IDLE;
    endcase
  end

  // Address/data follow the grant; IDLE shows the CPU port with MEM_CEn high.
  always_comb begin
    cpu_req = '{cen: bus.CPU_CEn, wen: bus.CPU_WEn, ben: bus.CPU_BEn,
                a: RAM_AW'(bus.CPU_A), di: bus.CPU_DI};
    dma_req = '{cen: bus.DMA_CEn, wen: bus.DMA_WEn, ben: bus.DMA_BEn,
                a: RAM_AW'(bus.DMA_A), di: bus.DMA_DI};
    mem_req     = (st_q == RA_DMA) ? dma_req : cpu_req;
    mem_req.cen = (st_q == RA_IDLE);
  end

  assign bus.MEM_CEn    = mem_req.cen;
  assign bus.MEM_WEn    = mem_req.wen;
  assign bus.MEM_BEn    = mem_req.ben;
  assign bus.MEM_A      = mem_req.a[AW-1:0];
  assign bus.MEM_DI     = mem_req.di;
  assign bus.CPU_READYn = cpu_rdy_n;
  assign bus.DMA_READYn = dma_rdy_n;
  assign bus.RD_DO      = bus.MEM_DO;
  assign bus.GNT        = st_q;

endmodule
